dpram_be: RTL and testbench



---
 rtl/dpram_pkg.sv | 22 ++
 rtl/dpram_rd_pipe.sv | 58 +++++
 rtl/dpram_be.sv | 100 ++++++++++
 tb/tb_dpram_be.sv | 233 +++++++++++++++++++++++
 4 files changed

// File: rtl/dpram_pkg.sv
// Shared widths, collision policy and read latency for the byte-enable dual-port RAM.
// Latency is 1 cycle, or 2 when DPRAM_OUTREG_EN is defined.
// Pure declarations: no handshake and no backpressure.
package dpram_pkg;

    localparam int DATA_W_DEF = 32;
    localparam int ADDR_W_DEF = 12;
    localparam int CNT_W_DEF  = 16;

    typedef enum logic [0:0] {
        A_WINS = 1'b0
    } coll_policy_e;

    localparam coll_policy_e COLL_POLICY = A_WINS;

`ifdef DPRAM_OUTREG_EN
    localparam int RD_LAT = 2;
`else
    localparam int RD_LAT = 1;
`endif

endpackage

// File: rtl/dpram_rd_pipe.sv
// Per-port rvalid/rdata pipeline: 1 stage, or 2 stages when DPRAM_OUTREG_EN is defined.
// Latency is RD_LAT cycles from in_vld; rdata holds its last value while rvalid is low.
// No backpressure: a result is presented exactly once and is never stalled.
module dpram_rd_pipe
    import dpram_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_vld,
    input  logic [DATA_W-1:0] in_dat,
    output logic              rvalid,
    output logic [DATA_W-1:0] rdata
);

    logic              vld1;
    logic [DATA_W-1:0] dat1;

    // Data loads only with a valid beat so the output holds between results.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld1 <= 1'b0;
            dat1 <= '0;
        end else begin
            vld1 <= in_vld;
            if (in_vld) begin
                dat1 <= in_dat;
            end
        end
    end

    generate
        if (RD_LAT == 2) begin : g_outreg
            logic              vld2;
            logic [DATA_W-1:0] dat2;

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    vld2 <= 1'b0;
                    dat2 <= '0;
                end else begin
                    vld2 <= vld1;
                    if (vld1) begin
                        dat2 <= dat1;
                    end
                end
            end

            assign rvalid = vld2;
            assign rdata  = dat2;
        end else begin : g_direct
            assign rvalid = vld1;
            assign rdata  = dat1;
        end
    endgenerate

endmodule

// File: rtl/dpram_be.sv
// True dual-port RAM with byte enables, read-first ports, and A-wins write-collision arbitration.
// Read data arrives RD_LAT cycles after the array read (RD_LAT = 2 with DPRAM_OUTREG_EN).
// Backpressure: port B gnt drops on a same-address write collision; port A is never stalled.
module dpram_be
    import dpram_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int CNT_W  = CNT_W_DEF
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                a_req,
    input  logic                a_we,
    input  logic [ADDR_W-1:0]   a_addr,
    input  logic [DATA_W-1:0]   a_wdata,
    input  logic [DATA_W/8-1:0] a_be,
    output logic                a_gnt,
    output logic                a_rvalid,
    output logic [DATA_W-1:0]   a_rdata,
    input  logic                b_req,
    input  logic                b_we,
    input  logic [ADDR_W-1:0]   b_addr,
    input  logic [DATA_W-1:0]   b_wdata,
    input  logic [DATA_W/8-1:0] b_be,
    output logic                b_gnt,
    output logic                b_rvalid,
    output logic [DATA_W-1:0]   b_rdata,
    output logic [CNT_W-1:0]    coll_cnt
);

    localparam int BE_W  = DATA_W / 8;
    localparam int DEPTH = 1 << ADDR_W;

    logic              coll;
    logic              a_wr, a_rd, b_wr, b_rd;
    logic              a_rd_q, b_rd_q;
    logic [DATA_W-1:0] ram_qa, ram_qb;
    logic [DATA_W-1:0] mem [DEPTH];

    assign coll  = a_req && b_req && a_we && b_we && (a_addr == b_addr);
    assign a_gnt = rst_n && a_req;
    assign b_gnt = rst_n && b_req && !((COLL_POLICY == A_WINS) && coll);

    assign a_wr = a_gnt && a_we;
    assign a_rd = a_gnt && !a_we;
    assign b_wr = b_gnt && b_we;
    assign b_rd = b_gnt && !b_we;

    // Non-blocking reads sample the array before this edge's writes land: read-first.
    always_ff @(posedge clk) begin
        if (a_rd) begin
            ram_qa <= mem[a_addr];
        end
        if (b_rd) begin
            ram_qb <= mem[b_addr];
        end
        for (int i = 0; i < BE_W; i++) begin
            if (a_wr && a_be[i]) begin
                mem[a_addr][8*i +: 8] <= a_wdata[8*i +: 8];
            end
            if (b_wr && b_be[i]) begin
                mem[b_addr][8*i +: 8] <= b_wdata[8*i +: 8];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_rd_q   <= 1'b0;
            b_rd_q   <= 1'b0;
            coll_cnt <= '0;
        end else begin
            a_rd_q <= a_rd;
            b_rd_q <= b_rd;
            if (coll && (coll_cnt != {CNT_W{1'b1}})) begin
                coll_cnt <= coll_cnt + CNT_W'(1);
            end
        end
    end

    dpram_rd_pipe #(.DATA_W(DATA_W)) u_rd_a (
        .clk    (clk),
        .rst_n  (rst_n),
        .in_vld (a_rd_q),
        .in_dat (ram_qa),
        .rvalid (a_rvalid),
        .rdata  (a_rdata)
    );

    dpram_rd_pipe #(.DATA_W(DATA_W)) u_rd_b (
        .clk    (clk),
        .rst_n  (rst_n),
        .in_vld (b_rd_q),
        .in_dat (ram_qb),
        .rvalid (b_rvalid),
        .rdata  (b_rdata)
    );

endmodule

// File: tb/tb_dpram_be.sv
// Scoreboard bench for dpram_be: stimulus pushes expected reads, a negedge monitor pops and compares.
module tb_dpram_be;
    import dpram_pkg::*;

    localparam int DW = 32;
    localparam int AW = 12;
    localparam int CW = 4;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          a_req = 1'b0, a_we = 1'b0, b_req = 1'b0, b_we = 1'b0;
    logic [AW-1:0] a_addr = '0, b_addr = '0;
    logic [DW-1:0] a_wdata = '0, b_wdata = '0;
    logic [3:0]    a_be = '0, b_be = '0;
    logic          a_gnt, b_gnt, a_rvalid, b_rvalid;
    logic [DW-1:0] a_rdata, b_rdata;
    logic [CW-1:0] coll_cnt;

    always #5 clk = ~clk;

    dpram_be #(.DATA_W(DW), .ADDR_W(AW), .CNT_W(CW)) dut (
        .clk(clk), .rst_n(rst_n),
        .a_req(a_req), .a_we(a_we), .a_addr(a_addr), .a_wdata(a_wdata), .a_be(a_be),
        .a_gnt(a_gnt), .a_rvalid(a_rvalid), .a_rdata(a_rdata),
        .b_req(b_req), .b_we(b_we), .b_addr(b_addr), .b_wdata(b_wdata), .b_be(b_be),
        .b_gnt(b_gnt), .b_rvalid(b_rvalid), .b_rdata(b_rdata),
        .coll_cnt(coll_cnt)
    );

    typedef struct {
        logic [31:0] d;
        int          due;
    } exp_t;

    int          cyc = 0;
    int          checks = 0;
    int          errors = 0;
    int          coll_m = 0;
    bit          mon_on = 1'b0;
    exp_t        qa[$];
    exp_t        qb[$];
    logic [31:0] mdl [0:4095];
    logic [31:0] last_a = '0;
    logic [31:0] last_b = '0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at cycle %0d", name, act, exp, cyc);
        end
    endtask

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] wd,
                                          input logic [3:0] be);
        logic [31:0] r;
        r = old;
        for (int i = 0; i < 4; i++) begin
            if (be[i]) r[8*i +: 8] = wd[8*i +: 8];
        end
        return r;
    endfunction

    // One clock of stimulus; entered and left at posedge+1.
    task automatic access(input logic ar, input logic aw, input logic [11:0] aad,
                          input logic [31:0] ad, input logic [3:0] abe,
                          input logic br, input logic bw, input logic [11:0] bad,
                          input logic [31:0] bd, input logic [3:0] bbe, output logic bg);
        logic        is_coll, eg_b;
        a_req = ar; a_we = aw; a_addr = aad; a_wdata = ad; a_be = abe;
        b_req = br; b_we = bw; b_addr = bad; b_wdata = bd; b_be = bbe;
        #1;
        is_coll = ar && br && aw && bw && (aad == bad);
        eg_b = br && !is_coll;
        chk("a_gnt", a_gnt, ar);
        chk("b_gnt", b_gnt, eg_b);
        if (ar && !aw) qa.push_back('{d: mdl[aad], due: cyc + 1 + RD_LAT});
        if (eg_b && !bw) qb.push_back('{d: mdl[bad], due: cyc + 1 + RD_LAT});
        if (ar && aw) mdl[aad] = merge(mdl[aad], ad, abe);
        if (eg_b && bw) mdl[bad] = merge(mdl[bad], bd, bbe);
        if (is_coll && coll_m < (1 << CW) - 1) coll_m++;
        bg = eg_b;
        @(posedge clk);
        #1;
        chk("coll_cnt", {28'd0, coll_cnt}, coll_m);
    endtask

    task automatic idle(input int n);
        logic g;
        for (int i = 0; i < n; i++) access(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, g);
    endtask

    always @(negedge clk) begin
        exp_t e;
        logic ea, eb;
        if (mon_on) begin
            ea = (qa.size() > 0) && (qa[0].due == cyc);
            chk("a_rvalid", a_rvalid, ea);
            if (ea) begin
                e = qa.pop_front();
                if (a_rvalid) chk("a_rdata", a_rdata, e.d);
                last_a = e.d;
            end else begin
                chk("a_rdata_hold", a_rdata, last_a);
            end
            eb = (qb.size() > 0) && (qb[0].due == cyc);
            chk("b_rvalid", b_rvalid, eb);
            if (eb) begin
                e = qb.pop_front();
                if (b_rvalid) chk("b_rdata", b_rdata, e.d);
                last_b = e.d;
            end else begin
                chk("b_rdata_hold", b_rdata, last_b);
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation still running at time %0t, limit 500000", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        logic        bg;
        logic        br, bw;
        logic [11:0] bad;
        logic [31:0] bd;
        logic [3:0]  bbe;

        repeat (3) @(posedge clk);
        #1;
        a_req = 1'b1;
        #1;
        chk("rst_a_gnt", a_gnt, 0);
        chk("rst_a_rvalid", a_rvalid, 0);
        chk("rst_b_rvalid", b_rvalid, 0);
        chk("rst_a_rdata", a_rdata, 0);
        chk("rst_b_rdata", b_rdata, 0);
        chk("rst_coll_cnt", {28'd0, coll_cnt}, 0);
        a_req = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        mon_on = 1'b1;

        for (int i = 0; i < 64; i++)
            access(1, 1, 12'(2*i), $urandom, 4'hF, 1, 1, 12'(2*i+1), $urandom, 4'hF, bg);

        // Full write then read-back on A; B stays idle.
        access(1, 1, 12'h010, 32'hDEADBEEF, 4'hF, 0, 0, 0, 0, 0, bg);
        access(1, 0, 12'h010, 0, 0, 0, 0, 0, 0, 0, bg);
        idle(3);

        // Partial write: expected 0x11BB33DD.
        access(1, 1, 12'h020, 32'h11223344, 4'hF, 0, 0, 0, 0, 0, bg);
        access(1, 1, 12'h020, 32'hAABBCCDD, 4'b0101, 0, 0, 0, 0, 0, bg);
        access(1, 0, 12'h020, 0, 0, 0, 0, 0, 0, 0, bg);
        access(1, 1, 12'h021, 32'h0, 4'h0, 0, 0, 0, 0, 0, bg);
        idle(3);

        // Read-first across ports.
        access(1, 1, 12'h030, 32'h0, 4'hF, 0, 0, 0, 0, 0, bg);
        access(1, 1, 12'h030, 32'h55, 4'hF, 1, 0, 12'h030, 0, 0, bg);
        access(0, 0, 0, 0, 0, 1, 0, 12'h030, 0, 0, bg);
        idle(3);

        // Write-write collision: A wins, B retries next cycle.
        access(1, 1, 12'h040, 32'h1, 4'hF, 1, 1, 12'h040, 32'h2, 4'hF, bg);
        access(0, 0, 0, 0, 0, 1, 1, 12'h040, 32'h2, 4'hF, bg);
        access(1, 0, 12'h040, 0, 0, 1, 0, 12'h040, 0, 0, bg);
        idle(3);

        // Streaming reads on both ports.
        for (int i = 0; i < 8; i++)
            access(1, 0, 12'(i), 0, 0, 1, 0, 12'(8 + i), 0, 0, bg);
        idle(4);

        // Reset right after a granted read: the result must be dropped.
        access(1, 0, 12'h010, 0, 0, 1, 0, 12'h020, 0, 0, bg);
        rst_n = 1'b0;
        qa.delete();
        qb.delete();
        last_a = '0;
        last_b = '0;
        coll_m = 0;
        a_req = 1'b1;
        b_req = 1'b1;
        #1;
        chk("rst_mid_a_gnt", a_gnt, 0);
        chk("rst_mid_b_gnt", b_gnt, 0);
        repeat (2) @(posedge clk);
        #1;
        a_req = 1'b0;
        b_req = 1'b0;
        rst_n = 1'b1;
        chk("post_rst_coll_cnt", {28'd0, coll_cnt}, 0);
        chk("post_rst_a_rdata", a_rdata, 0);
        idle(3);
        access(1, 0, 12'h010, 0, 0, 1, 0, 12'h020, 0, 0, bg);
        idle(3);

        // Randomised traffic on a few addresses to provoke collisions; B holds while stalled.
        bg = 1'b1;
        br = 0; bw = 0; bad = 0; bd = 0; bbe = 0;
        for (int n = 0; n < 600; n++) begin
            if (bg || !br) begin
                br  = ($urandom % 4) != 0;
                bw  = $urandom % 2;
                bad = 12'($urandom % 4);
                bd  = $urandom;
                bbe = 4'($urandom % 16);
            end
            access(($urandom % 4) != 0, $urandom % 2, 12'($urandom % 4), $urandom,
                   4'($urandom % 16), br, bw, bad, bd, bbe, bg);
        end
        idle(3);

        // Sustained collisions drive coll_cnt into saturation.
        for (int n = 0; n < 18; n++)
            access(1, 1, 12'h005, $urandom, 4'hF, 1, 1, 12'h005, 32'hCAFEF00D, 4'hF, bg);
        access(0, 0, 0, 0, 0, 1, 1, 12'h005, 32'hCAFEF00D, 4'hF, bg);
        access(1, 0, 12'h005, 0, 0, 1, 0, 12'h005, 0, 0, bg);
        idle(4);

        mon_on = 1'b0;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
